branch_target_pc_unit: RTL and testbench
========================================

// Module: branch_target_pc_unit
// PURPOSE
//  Program-counter stage that consumes the word-aligned branch offset (sign-extended immediate << 2)
//  and the pipeline's jump/branch decisions, computes the redirect target, and holds the fetch PC.
//  Sits between the ID/EX branch-resolution logic and instruction memory; drives IF and the IF/ID squash.
//  Handles stalls by parking a redirect that arrives mid-stall and applying it on release.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded by Reset
//  PC_INCR       32'd4          sequential fetch increment (bytes)
// PORTS
//  Clk                  in   1   single clock, all state updates on rising edge
//  Reset                in   1   asynchronous, active-high; clears all state immediately
//  Stall                in   1   1 = hold PC (hazard unit)
//  BranchTaken          in   1   conditional branch resolved taken this cycle
//  BranchBasePC         in   32  PC+4 of the branch instruction
//  BranchOffsetShifted  in   32  sign-extended immediate already shifted left 2
//  Jump                 in   1   j/jal redirect request
//  JumpTarget26         in   26  instr[25:0] of the jump
//  JumpBasePC           in   32  PC+4 of the jump instruction
//  JumpReg              in   1   jr redirect request
//  JumpRegAddr          in   32  register-sourced target
//  PCResult             out  32  current fetch address (registered)
//  PCPlus4              out  32  PCResult + PC_INCR (registered, not combinational)
//  InstrValid           out  1   0 = fetched slot is squashed/bubble (IF/ID flush)
//  RedirectPending      out  1   1 = redirect parked during stall
//  AlignFault           out  1   sticky misaligned-target flag (macro only; else constant 0)
// BEHAVIOUR
//  Reset (async): PCResult=RESET_VECTOR, PCPlus4=RESET_VECTOR+4, InstrValid=0, RedirectPending=0,
//   AlignFault=0, state=RUN, pending target=0. Reset mid-stall/mid-pending discards everything.
//  Targets (mod 2^32, carries dropped): branch = BranchBasePC + BranchOffsetShifted;
//   jump = {JumpBasePC[31:28], JumpTarget26, 2'b00}; jr = JumpRegAddr.
//  Request priority: JumpReg > Jump > BranchTaken; lower requests same cycle ignored.
//  FSM states: RUN, PEND.
//   RUN, Stall=0, no req : PC<=PC+PC_INCR, InstrValid<=1.
//   RUN, Stall=0, req    : PC<=target, InstrValid<=0 (one-cycle squash), stay RUN.
//   RUN, Stall=1, no req : all outputs hold.
//   RUN, Stall=1, req    : pend<=target, RedirectPending<=1, ->PEND; PC/InstrValid hold.
//   PEND, Stall=1        : hold; any new req ignored (first parked redirect wins).
//   PEND, Stall=0        : PC<=pend, InstrValid<=0, RedirectPending<=0, ->RUN; same-cycle req ignored.
//  Latency: redirect visible on PCResult one edge after request (RUN) or one edge after Stall falls (PEND).
//  PCPlus4 always updated together with PCResult (= new PC + PC_INCR).
//  Wrap: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: any selected target with [1:0]!=0 sets AlignFault (sticky until Reset)
//   and is forced to {t[31:2],2'b00} before loading/parking.
//  Undefined: target used unmodified; AlignFault tied 0; no checker logic synthesized.
// STRUCTURE
//  Package pc_unit_pkg: state enum {RUN, PEND}, redirect-source encoding {NONE, BR, J, JR},
//   default RESET_VECTOR, PC_INCR constant.
//  Sub-module pc_target_calc (combinational): priority select + branch adder + jump concat;
//   outputs target and valid request. Top holds registers and FSM.
// TESTING
//  Reset release, no stall, 3 cycles -> PCResult 0,4,8,12; InstrValid 0 then 1; PCPlus4 = PC+4.
//  PC=0x100, BranchTaken, BranchBasePC=0x104, Offset=0xFFFF_FFF0 -> next PCResult=0xF4, InstrValid=0 one cycle.
//  Jump+BranchTaken same cycle, JumpBasePC=0x9000_0010, Target26=0x000_0040 -> PCResult=0x9000_0100.
//  Stall=1, JumpReg to 0x200 then BranchTaken to 0x300 while stalled -> RedirectPending=1, PC held;
//   Stall=0 -> PCResult=0x200, RedirectPending=0, InstrValid=0.
//  Reset asserted while PEND -> outputs at reset values immediately, pending target never applied.
//  With PC_ALIGN_CHECK_EN, JumpReg to 0x203 -> PCResult=0x200, AlignFault=1 until Reset; without -> 0x203, 0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the fetch program-counter unit.
package pc_unit_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        J    = 2'd2,
        JR   = 2'd3
    } redir_src_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INCR      = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect source selection (jr > j > branch) and target formation; purely combinational.
module pc_target_calc
    import pc_unit_pkg::*;
(
    input  logic               branch_taken,
    input  logic        [31:0] branch_base_pc,
    input  logic signed [31:0] branch_offset,
    input  logic               jump,
    input  logic        [25:0] jump_target26,
    input  logic        [31:0] jump_base_pc,
    input  logic               jump_reg,
    input  logic        [31:0] jump_reg_addr,
    output logic        [31:0] target,
    output logic               req
);

    redir_src_t         src;
    logic signed [31:0] br_target;
    logic        [31:0] j_target;
    logic        [27:0] unused_jump_base;

    // Only the region bits of the jump's PC+4 survive into the target.
    assign unused_jump_base = jump_base_pc[27:0];

    assign br_target = $signed(branch_base_pc) + branch_offset;
    assign j_target  = {jump_base_pc[31:28], jump_target26, 2'b00};

    always_comb begin
        src = NONE;
        if (jump_reg)          src = JR;
        else if (jump)         src = J;
        else if (branch_taken) src = BR;
    end

    always_comb begin
        target = 32'h0000_0000;
        unique case (src)
            JR:      target = jump_reg_addr;
            J:       target = j_target;
            BR:      target = br_target;
            default: target = 32'h0000_0000;
        endcase
    end

    assign req = (src != NONE);

endmodule

// File: rtl/branch_target_pc_unit.sv
// Fetch PC register with redirect, stall parking and IF/ID squash.
// Optional macro PC_ALIGN_CHECK_EN adds sticky misaligned-target detection and word forcing.
module branch_target_pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] PC_INCR      = DEFAULT_PC_INCR
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchBasePC,
    input  logic [31:0] BranchOffsetShifted,
    input  logic        Jump,
    input  logic [25:0] JumpTarget26,
    input  logic [31:0] JumpBasePC,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegAddr,
    output logic [31:0] PCResult,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        RedirectPending,
    output logic        AlignFault
);

    pc_state_t   state, state_nxt;
    logic [31:0] tgt_raw, tgt_eff, pend_p0, pc_nxt;
    logic        req;
    logic        load_seq, load_tgt, load_pend, park, pc_we;

    pc_target_calc u_calc (
        .branch_taken  (BranchTaken),
        .branch_base_pc(BranchBasePC),
        .branch_offset ($signed(BranchOffsetShifted)),
        .jump          (Jump),
        .jump_target26 (JumpTarget26),
        .jump_base_pc  (JumpBasePC),
        .jump_reg      (JumpReg),
        .jump_reg_addr (JumpRegAddr),
        .target        (tgt_raw),
        .req           (req)
    );

`ifdef PC_ALIGN_CHECK_EN
    function automatic logic [31:0] align_word(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

    logic misalign;
    assign tgt_eff  = align_word(tgt_raw);
    assign misalign = |tgt_raw[1:0];
`else
    assign tgt_eff  = tgt_raw;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (Stall && req) state_nxt = PEND;
            PEND: if (!Stall)       state_nxt = RUN;
            default:                state_nxt = RUN;
        endcase
    end

    always_comb begin
        load_seq  = 1'b0;
        load_tgt  = 1'b0;
        load_pend = 1'b0;
        park      = 1'b0;
        unique case (state)
            RUN: begin
                load_seq = !Stall && !req;
                load_tgt = !Stall && req;
                park     = Stall && req;
            end
            PEND:    load_pend = !Stall;
            default: ;
        endcase
    end

    // The registered PCPlus4 doubles as the sequential next PC.
    assign pc_we  = load_seq || load_tgt || load_pend;
    assign pc_nxt = load_pend ? pend_p0 : (load_tgt ? tgt_eff : PCPlus4);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PCResult   <= RESET_VECTOR;
            PCPlus4    <= RESET_VECTOR + PC_INCR;
            InstrValid <= 1'b0;
            pend_p0    <= 32'h0000_0000;
        end else begin
            if (pc_we) begin
                PCResult   <= pc_nxt;
                PCPlus4    <= pc_nxt + PC_INCR;
                InstrValid <= load_seq;
            end
            if (park) pend_p0 <= tgt_eff;
        end
    end

    assign RedirectPending = (state == PEND);

`ifdef PC_ALIGN_CHECK_EN
    // Only targets actually taken or parked can raise the fault.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                               AlignFault <= 1'b0;
        else if ((load_tgt || park) && misalign) AlignFault <= 1'b1;
    end
`else
    assign AlignFault = 1'b0;
`endif

endmodule

// File: tb/tb_branch_target_pc_unit.sv
// Directed bench for branch_target_pc_unit; expectations follow PC_ALIGN_CHECK_EN when defined.
module tb_branch_target_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchBasePC = '0;
    logic [31:0] BranchOffsetShifted = '0;
    logic        Jump = 1'b0;
    logic [25:0] JumpTarget26 = '0;
    logic [31:0] JumpBasePC = '0;
    logic        JumpReg = 1'b0;
    logic [31:0] JumpRegAddr = '0;
    logic [31:0] PCResult, PCPlus4;
    logic        InstrValid, RedirectPending, AlignFault;

    int pass_cnt = 0;
    int total_cnt = 0;

    branch_target_pc_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchBasePC(BranchBasePC),
        .BranchOffsetShifted(BranchOffsetShifted),
        .Jump(Jump), .JumpTarget26(JumpTarget26), .JumpBasePC(JumpBasePC),
        .JumpReg(JumpReg), .JumpRegAddr(JumpRegAddr),
        .PCResult(PCResult), .PCPlus4(PCPlus4), .InstrValid(InstrValid),
        .RedirectPending(RedirectPending), .AlignFault(AlignFault)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_reqs();
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        JumpReg     = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        total_cnt++; if (PCResult !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", PCResult, 32'h0); else pass_cnt++;
        total_cnt++; if (PCPlus4 !== 32'h4) $display("FAIL reset_pcp4 got=%h exp=%h", PCPlus4, 32'h4); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL reset_iv got=%b exp=0", InstrValid); else pass_cnt++;
        total_cnt++; if (RedirectPending !== 1'b0) $display("FAIL reset_rp got=%b exp=0", RedirectPending); else pass_cnt++;
        total_cnt++; if (AlignFault !== 1'b0) $display("FAIL reset_af got=%b exp=0", AlignFault); else pass_cnt++;
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (PCResult !== exp_pc[i]) $display("FAIL seq_pc[%0d] got=%h exp=%h", i, PCResult, exp_pc[i]); else pass_cnt++;
            total_cnt++; if (PCPlus4 !== exp_pc[i] + 32'd4) $display("FAIL seq_pcp4[%0d] got=%h exp=%h", i, PCPlus4, exp_pc[i] + 32'd4); else pass_cnt++;
            total_cnt++; if (InstrValid !== 1'b1) $display("FAIL seq_iv[%0d] got=%b exp=1", i, InstrValid); else pass_cnt++;
        end
    endtask

    task automatic test_branch();
        JumpReg = 1'b1; JumpRegAddr = 32'h100;
        step();
        total_cnt++; if (PCResult !== 32'h100) $display("FAIL jr_setup got=%h exp=%h", PCResult, 32'h100); else pass_cnt++;
        clear_reqs();
        BranchTaken = 1'b1; BranchBasePC = 32'h104; BranchOffsetShifted = 32'hFFFF_FFF0;
        step();
        total_cnt++; if (PCResult !== 32'hF4) $display("FAIL br_pc got=%h exp=%h", PCResult, 32'hF4); else pass_cnt++;
        total_cnt++; if (PCPlus4 !== 32'hF8) $display("FAIL br_pcp4 got=%h exp=%h", PCPlus4, 32'hF8); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL br_squash got=%b exp=0", InstrValid); else pass_cnt++;
        clear_reqs();
        step();
        total_cnt++; if (PCResult !== 32'hF8) $display("FAIL br_after got=%h exp=%h", PCResult, 32'hF8); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b1) $display("FAIL br_after_iv got=%b exp=1", InstrValid); else pass_cnt++;
    endtask

    task automatic test_priority();
        Jump = 1'b1; JumpBasePC = 32'h9000_0010; JumpTarget26 = 26'h000_0040;
        BranchTaken = 1'b1; BranchBasePC = 32'h1000; BranchOffsetShifted = 32'h20;
        step();
        total_cnt++; if (PCResult !== 32'h9000_0100) $display("FAIL j_over_br got=%h exp=%h", PCResult, 32'h9000_0100); else pass_cnt++;
        total_cnt++; if (PCPlus4 !== 32'h9000_0104) $display("FAIL j_pcp4 got=%h exp=%h", PCPlus4, 32'h9000_0104); else pass_cnt++;
        JumpReg = 1'b1; JumpRegAddr = 32'h440;
        step();
        total_cnt++; if (PCResult !== 32'h440) $display("FAIL jr_over_j got=%h exp=%h", PCResult, 32'h440); else pass_cnt++;
        clear_reqs();
        JumpRegAddr = 32'h0; Jump = 1'b1;
        step();
        clear_reqs();
        total_cnt++; if (PCResult !== 32'h9000_0100) $display("FAIL j_again got=%h exp=%h", PCResult, 32'h9000_0100); else pass_cnt++;
    endtask

    task automatic test_stall_pend();
        Stall = 1'b1;
        step();
        total_cnt++; if (PCResult !== 32'h9000_0100) $display("FAIL stall_hold got=%h exp=%h", PCResult, 32'h9000_0100); else pass_cnt++;
        total_cnt++; if (RedirectPending !== 1'b0) $display("FAIL stall_norp got=%b exp=0", RedirectPending); else pass_cnt++;
        JumpReg = 1'b1; JumpRegAddr = 32'h200;
        step();
        clear_reqs();
        total_cnt++; if (RedirectPending !== 1'b1) $display("FAIL park_rp got=%b exp=1", RedirectPending); else pass_cnt++;
        total_cnt++; if (PCResult !== 32'h9000_0100) $display("FAIL park_hold got=%h exp=%h", PCResult, 32'h9000_0100); else pass_cnt++;
        BranchTaken = 1'b1; BranchBasePC = 32'h300; BranchOffsetShifted = 32'h0;
        step();
        clear_reqs();
        total_cnt++; if (PCResult !== 32'h9000_0100) $display("FAIL pend_hold got=%h exp=%h", PCResult, 32'h9000_0100); else pass_cnt++;
        Stall = 1'b0;
        step();
        total_cnt++; if (PCResult !== 32'h200) $display("FAIL release_pc got=%h exp=%h", PCResult, 32'h200); else pass_cnt++;
        total_cnt++; if (PCPlus4 !== 32'h204) $display("FAIL release_pcp4 got=%h exp=%h", PCPlus4, 32'h204); else pass_cnt++;
        total_cnt++; if (RedirectPending !== 1'b0) $display("FAIL release_rp got=%b exp=0", RedirectPending); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b0) $display("FAIL release_iv got=%b exp=0", InstrValid); else pass_cnt++;
        step();
        total_cnt++; if (PCResult !== 32'h204) $display("FAIL release_next got=%h exp=%h", PCResult, 32'h204); else pass_cnt++;
    endtask

    task automatic test_reset_in_pend();
        Stall = 1'b1; JumpReg = 1'b1; JumpRegAddr = 32'h500;
        step();
        clear_reqs();
        total_cnt++; if (RedirectPending !== 1'b1) $display("FAIL rpend_rp got=%b exp=1", RedirectPending); else pass_cnt++;
        #2 Reset = 1'b1;
        #1;
        total_cnt++; if (PCResult !== 32'h0) $display("FAIL async_rst_pc got=%h exp=%h", PCResult, 32'h0); else pass_cnt++;
        total_cnt++; if (RedirectPending !== 1'b0) $display("FAIL async_rst_rp got=%b exp=0", RedirectPending); else pass_cnt++;
        Stall = 1'b0;
        step();
        Reset = 1'b0;
        step();
        total_cnt++; if (PCResult !== 32'h4) $display("FAIL discard_pend got=%h exp=%h", PCResult, 32'h4); else pass_cnt++;
        total_cnt++; if (InstrValid !== 1'b1) $display("FAIL discard_iv got=%b exp=1", InstrValid); else pass_cnt++;
    endtask

    task automatic test_wrap();
        JumpReg = 1'b1; JumpRegAddr = 32'hFFFF_FFFC;
        step();
        clear_reqs();
        total_cnt++; if (PCPlus4 !== 32'h0) $display("FAIL wrap_pcp4 got=%h exp=%h", PCPlus4, 32'h0); else pass_cnt++;
        step();
        total_cnt++; if (PCResult !== 32'h0) $display("FAIL wrap_pc got=%h exp=%h", PCResult, 32'h0); else pass_cnt++;
        total_cnt++; if (AlignFault !== 1'b0) $display("FAIL wrap_af got=%b exp=0", AlignFault); else pass_cnt++;
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        logic        exp_af;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h200; exp_af = 1'b1;
`else
        exp_pc = 32'h203; exp_af = 1'b0;
`endif
        JumpReg = 1'b1; JumpRegAddr = 32'h203;
        step();
        clear_reqs();
        total_cnt++; if (PCResult !== exp_pc) $display("FAIL align_pc got=%h exp=%h", PCResult, exp_pc); else pass_cnt++;
        total_cnt++; if (AlignFault !== exp_af) $display("FAIL align_af got=%b exp=%b", AlignFault, exp_af); else pass_cnt++;
        step();
        total_cnt++; if (AlignFault !== exp_af) $display("FAIL align_sticky got=%b exp=%b", AlignFault, exp_af); else pass_cnt++;
        Reset = 1'b1;
        #1;
        total_cnt++; if (AlignFault !== 1'b0) $display("FAIL align_clr got=%b exp=0", AlignFault); else pass_cnt++;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_stall_pend();
        test_reset_in_pend();
        test_wrap();
        test_align();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
